// File: rtl/cacheline_adapter_if.sv
// Cache-to-memory bundle: line-wide dfp request/response side plus beat-wide bmem burst side.
// slave = the adapter; master = the cache requester and burst memory that surround it.
`timescale 1ns/1ps
interface cacheline_adapter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
);
  logic [31:0]           dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_WIDTH-1:0] dfp_wdata;
  logic [LINE_WIDTH-1:0] dfp_rdata;
  logic                  dfp_resp;

  logic [31:0]           bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [31:0]           bmem_raddr;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Turns one line read/write into a 4-beat burst; dfp_resp one cycle after the last read beat / accepted write beat.
// Backpressure: bmem_ready gates the read issue and every write beat; read beats are taken whenever bmem_rvalid.
`timescale 1ns/1ps
module cacheline_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adapter_if.slave  bus
);
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_BURST, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [31:0]           addr_q, addr_nxt;
  logic [LINE_WIDTH-1:0] line_q, line_nxt;
  logic [31:0]           addr_aligned;
  logic                  unused_inputs;

  assign addr_aligned  = {bus.dfp_addr[31:OFF_W], OFF_W'(0)};
  // Return-beat address tags and the in-line byte offset carry no information here.
  assign unused_inputs = ^{bus.bmem_raddr, bus.dfp_addr[OFF_W-1:0]};
  // One register serves as write staging and read assembly buffer.
  assign bus.dfp_rdata = line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      line_q <= line_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    addr_nxt       = addr_q;
    line_nxt       = line_q;
    bus.dfp_resp   = 1'b0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_addr  = '0;
    bus.bmem_wdata = '0;

    unique case (state)
      IDLE: begin
        // Write takes priority so a both-high request still behaves deterministically.
        if (bus.dfp_write) begin
          line_nxt  = bus.dfp_wdata;
          addr_nxt  = addr_aligned;
          cnt_nxt   = '0;
          state_nxt = WR_BURST;
        end else if (bus.dfp_read && bus.bmem_ready) begin
          bus.bmem_read = 1'b1;
          bus.bmem_addr = addr_aligned;
          addr_nxt      = addr_aligned;
          cnt_nxt       = '0;
          state_nxt     = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus.bmem_rvalid) begin
          line_nxt[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] = bus.bmem_rdata;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = DONE;
        end
      end

      WR_BURST: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = line_q[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH];
        if (bus.bmem_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = DONE;
        end
      end

      DONE: begin
        bus.dfp_resp = 1'b1;
        state_nxt    = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed and randomized line reads/writes against a line/beat reference model with a cycle-level protocol check.
`timescale 1ns/1ps
module tb_cacheline_adapter;
  localparam int LW = 256;
  localparam int BW = 64;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [LW-1:0] last_rd_line;

  cacheline_adapter_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) bus ();
  cacheline_adapter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_resp"},  bus.dfp_resp,   1'b0);
    check({tag, "_read"},  bus.bmem_read,  1'b0);
    check({tag, "_write"}, bus.bmem_write, 1'b0);
    check({tag, "_addr"},  bus.bmem_addr,  32'h0);
    check({tag, "_wdata"}, bus.bmem_wdata, 64'h0);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Read: expected line is the four returned beats stacked in arrival order.
  task automatic do_read(input logic [31:0] addr, input logic [LW-1:0] line,
                         input int stall, input int gap_at, input int gap_max);
    bus.dfp_addr  = addr;
    bus.dfp_read  = 1'b1;
    bus.dfp_write = 1'b0;
    for (int c = 0; c < stall; c++) begin
      bus.bmem_ready = 1'b0;
      @(negedge clk);
      check("rd_stall_read", bus.bmem_read, 1'b0);
      next_cycle();
    end
    bus.bmem_ready = 1'b1;
    @(negedge clk);
    check("rd_issue", bus.bmem_read, 1'b1);
    check("rd_addr", bus.bmem_addr, addr & 32'hFFFF_FFE0);
    next_cycle();
    bus.dfp_addr = $urandom;
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = (i == gap_at) ? 1 : ((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      for (int g = 0; g < gap; g++) begin
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = {$urandom, $urandom};
        bus.bmem_ready  = 1'($urandom);
        @(negedge clk);
        check("rd_gap_resp", bus.dfp_resp, 1'b0);
        check("rd_gap_read", bus.bmem_read, 1'b0);
        next_cycle();
      end
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = line[BW*i +: BW];
      bus.bmem_raddr  = addr & 32'hFFFF_FFE0;
      @(negedge clk);
      check("rd_beat_resp", bus.dfp_resp, 1'b0);
      next_cycle();
    end
    bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    check("rd_resp", bus.dfp_resp, 1'b1);
    check("rd_data", bus.dfp_rdata, line);
    next_cycle();
    bus.dfp_read = 1'b0;
    @(negedge clk);
    check("rd_resp_single", bus.dfp_resp, 1'b0);
    check("rd_data_hold", bus.dfp_rdata, line);
    last_rd_line = line;
    next_cycle();
  endtask

  // Write: beats must leave in slot order at the aligned address, holding through ready-low cycles.
  task automatic do_write(input logic [31:0] addr, input logic [LW-1:0] line, input logic both,
                          input int stall_beat, input int stall_len, input bit rand_stall);
    int nbeat;
    int held;
    int cyc;
    bus.dfp_addr   = addr;
    bus.dfp_wdata  = line;
    bus.dfp_write  = 1'b1;
    bus.dfp_read   = both;
    bus.bmem_ready = 1'($urandom);
    @(negedge clk);
    check("wr_req_read", bus.bmem_read, 1'b0);
    check("wr_req_write", bus.bmem_write, 1'b0);
    next_cycle();
    bus.dfp_addr  = $urandom;
    bus.dfp_wdata = rand_line();
    nbeat = 0;
    held  = 0;
    cyc   = 0;
    while (nbeat < 4 && cyc < 64) begin
      logic rdy;
      if (rand_stall) rdy = ($urandom_range(0, 2) != 0);
      else            rdy = !(nbeat == stall_beat && held < stall_len);
      bus.bmem_ready = rdy;
      @(negedge clk);
      check("wr_valid", bus.bmem_write, 1'b1);
      check("wr_addr", bus.bmem_addr, addr & 32'hFFFF_FFE0);
      check("wr_beat", bus.bmem_wdata, line[BW*nbeat +: BW]);
      check("wr_no_read", bus.bmem_read, 1'b0);
      check("wr_no_resp", bus.dfp_resp, 1'b0);
      if (rdy) nbeat++;
      else held++;
      next_cycle();
      cyc++;
    end
    check("wr_beat_count", nbeat, 4);
    bus.bmem_ready = 1'($urandom);
    @(negedge clk);
    check("wr_resp", bus.dfp_resp, 1'b1);
    check("wr_done_write", bus.bmem_write, 1'b0);
    next_cycle();
    bus.dfp_write = 1'b0;
    bus.dfp_read  = 1'b0;
    @(negedge clk);
    check("wr_resp_single", bus.dfp_resp, 1'b0);
    check("wr_idle_write", bus.bmem_write, 1'b0);
    next_cycle();
  endtask

  task automatic stray_beat(input logic [LW-1:0] expect_line);
    bus.bmem_rvalid = 1'b1;
    bus.bmem_rdata  = {$urandom, $urandom};
    @(negedge clk);
    check("stray_resp", bus.dfp_resp, 1'b0);
    next_cycle();
    bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rdata", bus.dfp_rdata, expect_line);
    check("stray_resp2", bus.dfp_resp, 1'b0);
    next_cycle();
  endtask

  initial begin
    rst             = 1'b1;
    bus.dfp_addr    = '0;
    bus.dfp_read    = 1'b0;
    bus.dfp_write   = 1'b0;
    bus.dfp_wdata   = '0;
    bus.bmem_ready  = 1'b0;
    bus.bmem_raddr  = '0;
    bus.bmem_rdata  = '0;
    bus.bmem_rvalid = 1'b0;
    last_rd_line    = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    check("reset_rdata", bus.dfp_rdata, '0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");
    next_cycle();

    do_read(32'h0000_1234, {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, 0, 2, 0);
    stray_beat(last_rd_line);
    do_write(32'h8000_0040, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 1'b0, 1, 2, 1'b0);
    do_read($urandom, rand_line(), 3, -1, 0);
    do_write($urandom, rand_line(), 1'b1, -1, 0, 1'b0);

    // Reset partway through a read, then stray beats from the aborted burst.
    bus.dfp_addr   = 32'h0000_4567;
    bus.dfp_read   = 1'b1;
    bus.bmem_ready = 1'b1;
    @(negedge clk);
    check("rst_issue", bus.bmem_read, 1'b1);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = {$urandom, $urandom};
      next_cycle();
    end
    bus.bmem_rvalid = 1'b0;
    bus.dfp_read    = 1'b0;
    rst             = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    check("rst_mid_rdata", bus.dfp_rdata, '0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      check("rst_stray_resp", bus.dfp_resp, 1'b0);
      next_cycle();
    end
    bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    check("rst_stray_rdata", bus.dfp_rdata, '0);
    next_cycle();
    do_read(32'h0000_4567, rand_line(), 0, -1, 1);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_read($urandom, rand_line(), int'($urandom_range(0, 2)), -1, 2);
        if ($urandom_range(0, 1) == 1) stray_beat(last_rd_line);
      end else begin
        do_write($urandom, rand_line(), 1'($urandom), -1, 0, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
